fifo_rd_sched: RTL and testbench

FIFO_RD_SCHED -- requirements
Module: fifo_rd_sched

---
 rtl/fifo_rd_sched.sv | 93 +++++++++
 tb/tb_fifo_rd_sched.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_sched.sv
// rtl/fifo_rd_sched.sv - FIFO read-side pop scheduler with registered handshake output and inter-word gap
// Define FIFO_RD_SCHED_STATS_EN to add a saturating pop_count output.
module fifo_rd_sched #(
  parameter int DATA_WIDTH = 8,
  parameter int GAP_WIDTH  = 4
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  enable,
  input  logic [GAP_WIDTH-1:0]  gap_cfg,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
`ifdef FIFO_RD_SCHED_STATS_EN
  output logic [15:0]           pop_count,
`endif
  output logic                  busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_VALID = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0]           state;
  logic [GAP_WIDTH-1:0] gap_cnt;
  logic                 handshake;
  logic                 can_pop;

  assign handshake = (state == ST_VALID) && out_ready;
  assign can_pop   = enable && !rempty && !rrst;
  assign out_valid = (state == ST_VALID);
  assign busy      = (state != ST_IDLE);

  // A held word is only replaced in the same cycle it is accepted, and only when no gap follows.
  always_comb begin
    rinc = 1'b0;
    case (state)
      ST_IDLE:  rinc = can_pop;
      ST_VALID: rinc = can_pop && handshake && (gap_cfg == '0);
      default:  rinc = 1'b0;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state    <= ST_IDLE;
      out_data <= '0;
      gap_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rinc) begin
            out_data <= rdata;
            state    <= ST_VALID;
          end
        end
        ST_VALID: begin
          if (handshake) begin
            if (gap_cfg != '0) begin
              gap_cnt <= gap_cfg;
              state   <= ST_GAP;
            end else if (rinc) begin
              out_data <= rdata;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_GAP: begin
          gap_cnt <= gap_cnt - 1'b1;
          if (gap_cnt <= GAP_WIDTH'(1)) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FIFO_RD_SCHED_STATS_EN
  always_ff @(posedge rclk) begin
    if (rrst) begin
      pop_count <= '0;
    end else if (rinc && (pop_count != 16'hFFFF)) begin
      pop_count <= pop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_sched.sv
// tb/tb_fifo_rd_sched.sv - scoreboard bench for fifo_rd_sched with a queue-based FIFO and behavioural checks
// Build with FIFO_RD_SCHED_STATS_EN defined to also exercise pop_count.
module tb_fifo_rd_sched;

  localparam int DW = 8;
  localparam int GW = 4;

  logic          rclk      = 1'b0;
  logic          rrst      = 1'b1;
  logic          enable    = 1'b0;
  logic [GW-1:0] gap_cfg   = '0;
  logic          rempty    = 1'b1;
  logic [DW-1:0] rdata     = '0;
  logic          out_ready = 1'b0;
  logic          rinc;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          busy;
`ifdef FIFO_RD_SCHED_STATS_EN
  logic [15:0]   pop_count;
`endif

  fifo_rd_sched #(.DATA_WIDTH(DW), .GAP_WIDTH(GW)) dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .enable    (enable),
    .gap_cfg   (gap_cfg),
    .rempty    (rempty),
    .rdata     (rdata),
    .rinc      (rinc),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef FIFO_RD_SCHED_STATS_EN
    .pop_count (pop_count),
`endif
    .busy      (busy)
  );

  always #5 rclk = ~rclk;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic          pop_pending = 1'b0;
  logic          mon_en      = 1'b0;
  logic          rst_edge    = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic upd();
    rempty = (fifo_q.size() == 0);
    rdata  = rempty ? '0 : fifo_q[0];
  endtask

  task automatic push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    upd();
  endtask

  // One clock: consume the FIFO head if the DUT popped, and on reset forget the word it held.
  task automatic step();
    logic [DW-1:0] tmp;
    @(posedge rclk);
    #1;
    if (pop_pending && fifo_q.size() > 0) tmp = fifo_q.pop_front();
    if (rst_edge) begin
      while (exp_q.size() > fifo_q.size()) tmp = exp_q.pop_front();
    end
    upd();
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    enable    = 1'b1;
    out_ready = 1'b1;
    while ((fifo_q.size() != 0 || exp_q.size() != 0 || busy) && n < max_cycles) begin
      step();
      n++;
    end
    chk("drain_done", int'(n < max_cycles), 1);
  endtask

  always @(posedge rclk) rst_edge = rrst;

  logic          prev_hold      = 1'b0;
  logic [DW-1:0] prev_data      = '0;
  logic          exp_valid_next = 1'b0;
  logic          tracking       = 1'b0;
  int            gcount         = 0;
  int            gexp           = 0;

  always @(negedge rclk) begin
    if (mon_en) begin
      if (rst_edge) begin
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_busy", busy, 0);
      end
      if (rrst) chk("rinc_in_reset", rinc, 0);
      chk("rinc_while_empty", int'(rinc && rempty), 0);
      chk("rinc_while_held", int'(rinc && out_valid && !out_ready), 0);
      if (prev_hold && out_valid) chk("hold_stable", out_data, prev_data);
      if (exp_valid_next) chk("latency_valid", out_valid, 1);
      exp_valid_next = 1'b0;
      if (!busy && enable && !rempty && !rrst) begin
        chk("idle_pop", rinc, 1);
        exp_valid_next = 1'b1;
      end
      if (rrst) begin
        tracking = 1'b0;
      end else if (tracking) begin
        if (out_valid) begin
          chk("stream_no_gap", gexp, 0);
          tracking = 1'b0;
        end else if (busy) begin
          gcount++;
        end else begin
          chk("gap_len", gcount, gexp);
          tracking = 1'b0;
        end
      end
      if (out_valid && out_ready && !rrst) begin
        chk("word_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("out_data", out_data, exp_q.pop_front());
        tracking = 1'b1;
        gcount   = 0;
        gexp     = gap_cfg;
      end
      prev_hold   = out_valid && !out_ready && !rrst;
      prev_data   = out_data;
      pop_pending = rinc;
    end
  end

  initial begin
    // Reset with a non-empty FIFO and enable high.
    rrst      = 1'b1;
    enable    = 1'b1;
    out_ready = 1'b1;
    push(8'h3C);
    step();
    mon_en = 1'b1;
    step();
    rrst = 1'b0;
    drain(50);

    // Single word.
    gap_cfg = 0;
    push(8'hA5);
    step();
    drain(50);

    // Backpressure: six cycles held before acceptance.
    out_ready = 1'b0;
    push(8'h11); push(8'h22); push(8'h33);
    repeat (6) step();
    drain(50);

    // Streaming four words.
    gap_cfg = 0;
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    drain(50);

    // Pacing with a three-cycle gap.
    gap_cfg = 3;
    push(8'h5A); push(8'hC3);
    drain(50);

    // Reset while a word is held.
    gap_cfg   = 0;
    out_ready = 1'b0;
    push(8'h77); push(8'h88);
    repeat (3) step();
    rrst = 1'b1;
    step();
    rrst = 1'b0;
    drain(50);

    // Reset in the middle of a gap.
    gap_cfg = 8;
    push(8'h99); push(8'hAA);
    out_ready = 1'b1;
    repeat (4) step();
    rrst = 1'b1;
    step();
    rrst = 1'b0;
    drain(60);

    // gap_cfg changes while a gap is running.
    gap_cfg = 5;
    push(8'hBB); push(8'hCC);
    repeat (3) step();
    gap_cfg = 1;
    drain(60);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      enable    = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      if ($urandom % 5 == 0) gap_cfg = GW'($urandom_range(0, 3));
      if (($urandom % 3 == 0) && fifo_q.size() < 8) push(DW'($urandom));
      rrst = ($urandom % 150) == 0;
      step();
    end
    rrst = 1'b0;
    drain(200);

`ifdef FIFO_RD_SCHED_STATS_EN
    rrst = 1'b1;
    step();
    rrst = 1'b0;
    chk("pop_count_reset", pop_count, 0);
    gap_cfg = 0;
    enable = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      push(DW'(i));
      step();
    end
    drain(50);
    chk("pop_count_100", pop_count, 100);
    for (int i = 0; i < 70000; i++) begin
      push(DW'(i));
      step();
    end
    drain(50);
    chk("pop_count_sat", pop_count, 16'hFFFF);
    for (int i = 0; i < 5; i++) begin
      push(DW'(i));
      step();
    end
    drain(50);
    chk("pop_count_held", pop_count, 16'hFFFF);
    rrst = 1'b1;
    step();
    rrst = 1'b0;
    chk("pop_count_reset_after_sat", pop_count, 0);
`endif

    chk("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
